key_debouncer: RTL and testbench
================================

// Module: key_debouncer
// PURPOSE
//  Debounces one raw push-button input and generates press, release and auto-repeat events.
//  Sits directly downstream of the periodic divider (counter with level output, e.g. 1 kHz).
//  The divider's level output is rising-edge detected into a 1-cycle sample tick.
//  Events feed the game-control logic as single-cycle strobes in the clk domain.
// PARAMETERS
//  STABLE_TICKS   4    consecutive agreeing sample ticks needed to accept a press/release
//  HOLD_TICKS     50   ticks in HELD before first key_repeat
//  REPEAT_TICKS   10   ticks between subsequent key_repeat; 0 disables repeat
//  KEY_ACTIVE_LOW 0    1: key_raw=0 means pressed (inverted after synchroniser)
//  CNT_W          8    counter width; must satisfy 2**CNT_W > max(HOLD_TICKS, STABLE_TICKS, REPEAT_TICKS)
// PORTS
//  clk          in   1  system clock, single clock domain
//  rst          in   1  synchronous, active-high reset
//  tick_in      in   1  level output of upstream divider; sampled in clk domain
//  key_raw      in   1  asynchronous raw button pin
//  key_level    out  1  debounced pressed level
//  key_press    out  1  1-cycle strobe on accepted press
//  key_release  out  1  1-cycle strobe on accepted release
//  key_repeat   out  1  1-cycle strobe on auto-repeat while held
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; counters 0; sync flops 0; tick_d 0.
//  - Reset mid-operation: immediate return to IDLE; no release strobe is emitted.
//  - key_raw: 2-flop synchroniser, then optional inversion; result k. Latency: 2 clk.
//  - tick = tick_in & ~tick_d. tick_d is a register.
//  - tick_in already high when reset is released yields a tick in the first cycle after reset.
//  - FSM (registered outputs):
//    IDLE:   k=1 -> DB_PRESS, db_cnt=0.
//    DB_PRESS: k=0 in any cycle -> IDLE (bounce).
//      Otherwise, on each tick db_cnt++.
//      The tick making db_cnt==STABLE_TICKS -> HELD, key_press=1 next cycle, hold_cnt=0.
//    HELD:   key_level=1. k=0 -> DB_RELEASE, db_cnt=0; hold_cnt is preserved.
//      On tick, hold_cnt++ saturating at all-ones.
//      key_repeat is pulsed on the tick where hold_cnt becomes HOLD_TICKS.
//      Thereafter key_repeat is pulsed every REPEAT_TICKS ticks (a separate rep_cnt, reset on each pulse).
//    DB_RELEASE: key_level stays 1.
//      k=1 in any cycle -> HELD, resuming hold_cnt without re-emitting press.
//      On each tick, db_cnt++. The tick making db_cnt==STABLE_TICKS -> IDLE; key_release=1 next cycle; key_level=0.
//  - Simultaneous tick and input mismatch in the same cycle: mismatch wins; the counter is cleared and the state reverts.
//  - Strobes are exactly one clk wide and mutually exclusive in any cycle.
//  - key_level changes in the same cycle as its press/release strobe.
//  - Worst-case press latency: 2 clk + STABLE_TICKS tick periods + 1 clk.
//  - Repeat is not generated in DB_RELEASE.
// STRUCTURE
//  - Shared header key_defs.vh:
//    - 2-bit FSM state encodings (IDLE=0, DB_PRESS=1, HELD=2, DB_RELEASE=3);
//    - default tick-count constants shared with other input blocks.
//  - Sub-module edge_detect_rise (clk, rst, d, pulse) for tick generation.
//    It is reusable by other consumers of the divider output.
//  - Synchroniser stays inline (two flops).
// TESTING (STABLE_TICKS=4, HOLD_TICKS=50, REPEAT_TICKS=10; tick every 10 clk)
//  1. Clean press held 8 ticks, then clean release.
//     -> key_press once, ~4 ticks after k rises; key_level 1.
//     -> key_release once, 4 ticks after release; no key_repeat.
//  2. Bounce: key_raw toggles every 3 clk for 60 clk, then stays 1.
//     -> exactly one key_press, timed from the final rising edge; no release.
//  3. Hold for 80 ticks.
//     -> key_repeat at hold ticks 50, 60, 70, 80 (4 strobes); key_press once.
//  4. Release glitch: in HELD, key_raw=0 for 2 ticks, then back to 1.
//     -> no key_release; key_level stays 1; repeat cadence continues from preserved hold_cnt.
//  5. Reset asserted mid-DB_RELEASE.
//     -> all outputs 0 next cycle; no key_release; FSM IDLE.
//  6. REPEAT_TICKS=0, hold 100 ticks.
//     -> single key_repeat at tick 50 only.
//     -> tick_in held high across reset release: first tick 1 cycle after rst drops.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg
//   Shared definitions for the push-button input blocks.
//   - kd_state_t : 2-bit debouncer FSM state encoding
//                  (IDLE=0, DB_PRESS=1, HELD=2, DB_RELEASE=3)
//   - KD_*_DEF   : default tick-count constants shared with other input blocks
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } kd_state_t;

  localparam int KD_STABLE_TICKS_DEF = 4;
  localparam int KD_HOLD_TICKS_DEF   = 50;
  localparam int KD_REPEAT_TICKS_DEF = 10;
  localparam int KD_CNT_W_DEF        = 8;

endpackage

// File: rtl/key_debouncer_edge_detect_rise.sv
// edge_detect_rise
//   Turns a level signal into a one-clock pulse on its rising edge.
//   Used to derive the debouncer sample tick from the divider's level output;
//   reusable by any other consumer of that divider.
// Ports
//   clk   in  1  system clock
//   rst   in  1  synchronous active-high reset (clears the delay flop)
//   d     in  1  level input
//   pulse out 1  d & ~d_delayed
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic r_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= 1'b0;
    end else begin
      r_d <= d;
    end
  end

  // Delay flop resets to 0, so a level already high at reset release
  // produces a pulse in the first cycle after reset.
  assign pulse = d & ~r_d;

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer
//   Debounces one raw push-button and produces press, release and
//   auto-repeat strobes for the game-control logic.
// Parameters
//   STABLE_TICKS   agreeing sample ticks needed to accept a press/release
//   HOLD_TICKS     held ticks before the first repeat
//   REPEAT_TICKS   ticks between later repeats (0 disables repeat)
//   KEY_ACTIVE_LOW 1: key_raw=0 means pressed
//   CNT_W          counter width (2**CNT_W > all tick counts)
// Ports
//   clk         in  1  system clock
//   rst         in  1  synchronous active-high reset
//   tick_in     in  1  divider level output, rising edge = sample tick
//   key_raw     in  1  asynchronous button pin
//   key_level   out 1  debounced pressed level
//   key_press   out 1  one-cycle strobe on accepted press
//   key_release out 1  one-cycle strobe on accepted release
//   key_repeat  out 1  one-cycle strobe on auto-repeat while held
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS   = KD_STABLE_TICKS_DEF,
  parameter int HOLD_TICKS     = KD_HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS   = KD_REPEAT_TICKS_DEF,
  parameter bit KEY_ACTIVE_LOW = 1'b0,
  parameter int CNT_W          = KD_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] C_HOLD   = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] C_REPEAT = CNT_W'(REPEAT_TICKS);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + C_ONE;
  endfunction

  logic             r_sync1;
  logic             r_sync2;
  logic             w_k;
  logic             w_tick;
  kd_state_t        r_state;
  kd_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] w_db_nxt;
  logic [CNT_W-1:0] w_db_inc;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [CNT_W-1:0] w_rep_nxt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_repeat;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_repeat_nxt;

  // ---- stage: input conditioning (sync + tick edge) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_k = r_sync2 ^ KEY_ACTIVE_LOW;

  edge_detect_rise u_tick_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (tick_in),
    .pulse (w_tick)
  );

  assign w_db_inc = r_db_cnt + C_ONE;

  // ---- stage: FSM next-state / registered outputs ----
  always_comb begin
    w_state_nxt   = r_state;
    w_db_nxt      = r_db_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_rep_nxt     = r_rep_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_repeat_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_k) begin
          w_state_nxt = ST_DB_PRESS;
          w_db_nxt    = '0;
        end
      end

      // A mismatch takes priority over a coincident tick.
      ST_DB_PRESS: begin
        if (!w_k) begin
          w_state_nxt = ST_IDLE;
          w_db_nxt    = '0;
        end else if (w_tick) begin
          w_db_nxt = w_db_inc;
          if (w_db_inc == C_STABLE) begin
            w_state_nxt = ST_HELD;
            w_press_nxt = 1'b1;
            w_db_nxt    = '0;
            w_hold_nxt  = '0;
            w_rep_nxt   = '0;
          end
        end
      end

      ST_HELD: begin
        if (!w_k) begin
          w_state_nxt = ST_DB_RELEASE;
          w_db_nxt    = '0;
        end else if (w_tick) begin
          w_hold_nxt = sat_inc(r_hold_cnt);
          if ((r_hold_cnt < C_HOLD) && (w_hold_nxt == C_HOLD)) begin
            w_repeat_nxt = 1'b1;
            w_rep_nxt    = '0;
          end else if ((REPEAT_TICKS != 0) && (r_hold_cnt >= C_HOLD)) begin
            // Saturated hold_cnt stays >= HOLD, so the cadence keeps running.
            w_rep_nxt = r_rep_cnt + C_ONE;
            if (w_rep_nxt == C_REPEAT) begin
              w_repeat_nxt = 1'b1;
              w_rep_nxt    = '0;
            end
          end
        end
      end

      // hold_cnt/rep_cnt are left untouched so a release glitch resumes the cadence.
      ST_DB_RELEASE: begin
        if (w_k) begin
          w_state_nxt = ST_HELD;
          w_db_nxt    = '0;
        end else if (w_tick) begin
          w_db_nxt = w_db_inc;
          if (w_db_inc == C_STABLE) begin
            w_state_nxt   = ST_IDLE;
            w_release_nxt = 1'b1;
            w_db_nxt      = '0;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_db_nxt    = '0;
      end
    endcase

    w_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_DB_RELEASE);
  end

  // ---- stage: state and output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_db_cnt   <= w_db_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
      r_level    <= w_level_nxt;
      r_press    <= w_press_nxt;
      r_release  <= w_release_nxt;
      r_repeat   <= w_repeat_nxt;
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_repeat  = r_repeat;

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer
//   Two instances (REPEAT_TICKS=10 and REPEAT_TICKS=0) share all inputs.
//   A behavioural model tracks debounced level, disagreement run length
//   and total held ticks, and every cycle is compared against it.
module tb_key_debouncer;

  localparam int STABLE = 4;
  localparam int HOLD   = 50;
  localparam int REP_A  = 10;
  localparam int REP_B  = 0;
  localparam int DIV    = 10;

  logic clk = 1'b0;
  logic rst;
  logic tick_in;
  logic key_raw;
  logic lvl_a, prs_a, rel_a, rpt_a;
  logic lvl_b, prs_b, rel_b, rpt_b;

  key_debouncer #(.STABLE_TICKS(STABLE), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP_A),
                  .KEY_ACTIVE_LOW(1'b0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .tick_in(tick_in), .key_raw(key_raw),
    .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a), .key_repeat(rpt_a));

  key_debouncer #(.STABLE_TICKS(STABLE), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP_B),
                  .KEY_ACTIVE_LOW(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .tick_in(tick_in), .key_raw(key_raw),
    .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b), .key_repeat(rpt_b));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         m_s1, m_s2, m_td;
  bit         m_level [2];
  int         m_run   [2] = '{-1, -1};   // -1: k agrees with level
  int         m_total [2];               // ticks spent held since the press
  logic [3:0] m_exp   [2] = '{4'b0, 4'b0};

  always @(posedge clk) begin : model
    bit k, tk, prs, rls, rpt;
    int r;
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_td = 1'b0;
      for (int u = 0; u < 2; u++) begin
        m_level[u] = 1'b0; m_run[u] = -1; m_total[u] = 0; m_exp[u] = 4'b0;
      end
    end else begin
      k  = m_s2;
      tk = tick_in & ~m_td;
      m_td = tick_in; m_s2 = m_s1; m_s1 = key_raw;
      for (int u = 0; u < 2; u++) begin
        r = (u == 0) ? REP_A : REP_B;
        prs = 1'b0; rls = 1'b0; rpt = 1'b0;
        if (k != m_level[u]) begin
          if (m_run[u] < 0) m_run[u] = 0;          // disagreement starts; tick not counted
          else if (tk) begin
            m_run[u]++;
            if (m_run[u] == STABLE) begin
              m_level[u] = k; m_run[u] = -1;
              if (k) begin prs = 1'b1; m_total[u] = 0; end
              else rls = 1'b1;
            end
          end
        end else if (m_run[u] >= 0) begin
          m_run[u] = -1;                            // disagreement abandoned
        end else if (m_level[u] && tk) begin
          m_total[u]++;
          rpt = (m_total[u] == HOLD) ||
                (r != 0 && m_total[u] > HOLD && ((m_total[u] - HOLD) % r) == 0);
        end
        m_exp[u] = {m_level[u], prs, rls, rpt};
      end
    end
  end

  // ---------------- checking infrastructure ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nprint = 0;
  int n_prs [2];
  int n_rel [2];
  int n_rpt [2];
  bit div_en = 1'b0;
  int div_cnt = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    logic [3:0] got [2];
    @(posedge clk);
    @(negedge clk);
    cyc++;
    got[0] = {lvl_a, prs_a, rel_a, rpt_a};
    got[1] = {lvl_b, prs_b, rel_b, rpt_b};
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (got[u] !== m_exp[u]) begin
        errors++;
        if (nprint < 30) begin
          nprint++;
          $display("FAIL model_cmp dut%0d cyc %0d got %b expected %b", u, cyc, got[u], m_exp[u]);
        end
      end
      n_prs[u] += int'(got[u][2]);
      n_rel[u] += int'(got[u][1]);
      n_rpt[u] += int'(got[u][0]);
    end
    if (div_en) begin
      div_cnt = (div_cnt + 1) % DIV;
      tick_in = (div_cnt < DIV / 2);
    end
  endtask

  task automatic run(input int n, input bit raw);
    key_raw = raw;
    repeat (n) step();
  endtask

  typedef struct {
    bit         rst;
    bit         tin;
    bit         raw;
    logic [3:0] exp;   // {level, press, release, repeat}
  } vec_t;

  vec_t tbl [25];

  initial begin
    int b_prs, b_rel, b_rpt, b_rpt_b, c0, lat;
    bit lvl_ok;

    rst = 1'b1; tick_in = 1'b0; key_raw = 1'b0;

    // Manual ticks, one per two cycles: press then release with STABLE=4.
    tbl[0]  = '{1, 0, 0, 4'b0000};  tbl[1]  = '{1, 0, 1, 4'b0000};
    tbl[2]  = '{0, 0, 1, 4'b0000};  tbl[3]  = '{0, 1, 1, 4'b0000};
    tbl[4]  = '{0, 0, 1, 4'b0000};  tbl[5]  = '{0, 1, 1, 4'b0000};
    tbl[6]  = '{0, 0, 1, 4'b0000};  tbl[7]  = '{0, 1, 1, 4'b0000};
    tbl[8]  = '{0, 0, 1, 4'b0000};  tbl[9]  = '{0, 1, 1, 4'b0000};
    tbl[10] = '{0, 0, 1, 4'b0000};  tbl[11] = '{0, 1, 1, 4'b1100};
    tbl[12] = '{0, 0, 1, 4'b1000};  tbl[13] = '{0, 1, 0, 4'b1000};
    tbl[14] = '{0, 0, 0, 4'b1000};  tbl[15] = '{0, 1, 0, 4'b1000};
    tbl[16] = '{0, 0, 0, 4'b1000};  tbl[17] = '{0, 1, 0, 4'b1000};
    tbl[18] = '{0, 0, 0, 4'b1000};  tbl[19] = '{0, 1, 0, 4'b1000};
    tbl[20] = '{0, 0, 0, 4'b1000};  tbl[21] = '{0, 1, 0, 4'b1000};
    tbl[22] = '{0, 0, 0, 4'b1000};  tbl[23] = '{0, 1, 0, 4'b0010};
    tbl[24] = '{0, 0, 0, 4'b0000};

    for (int i = 0; i < 25; i++) begin
      rst = tbl[i].rst; tick_in = tbl[i].tin; key_raw = tbl[i].raw;
      step();
      chk($sformatf("tbl%0d_a", i), int'({lvl_a, prs_a, rel_a, rpt_a}), int'(tbl[i].exp));
      chk($sformatf("tbl%0d_b", i), int'({lvl_b, prs_b, rel_b, rpt_b}), int'(tbl[i].exp));
    end

    // Test 1: clean press ~8 held ticks, clean release.
    div_en = 1'b1; div_cnt = 0;
    run(30, 1'b0);
    b_prs = n_prs[0]; b_rel = n_rel[0]; b_rpt = n_rpt[0];
    run(120, 1'b1);
    chk("t1_level_held", int'(lvl_a), 1);
    run(70, 1'b0);
    chk("t1_press_cnt", n_prs[0] - b_prs, 1);
    chk("t1_release_cnt", n_rel[0] - b_rel, 1);
    chk("t1_repeat_cnt", n_rpt[0] - b_rpt, 0);
    chk("t1_level_after", int'(lvl_a), 0);

    // Test 2: bounce every 3 clk for 60 clk, then stable high.
    b_prs = n_prs[0]; b_rel = n_rel[0];
    for (int s = 0; s < 20; s++) run(3, ((s % 2) == 0));
    chk("t2_no_press_in_bounce", n_prs[0] - b_prs, 0);
    key_raw = 1'b1;
    c0 = cyc; lat = -1;
    for (int t = 0; t < 100; t++) begin
      step();
      if (n_prs[0] != b_prs) begin lat = cyc - c0; break; end
    end
    chk("t2_press_seen", int'(lat >= 0), 1);
    chk("t2_latency_in_range", int'(lat >= 33 && lat <= 44), 1);

    // Test 3 / 6: hold 85 then 105 ticks from the press.
    b_rpt = n_rpt[0]; b_rpt_b = n_rpt[1];
    run(850, 1'b1);
    chk("t3_repeat_85ticks_a", n_rpt[0] - b_rpt, 4);
    chk("t6_repeat_85ticks_b", n_rpt[1] - b_rpt_b, 1);
    run(200, 1'b1);
    chk("t3_repeat_105ticks_a", n_rpt[0] - b_rpt, 6);
    chk("t6_repeat_105ticks_b", n_rpt[1] - b_rpt_b, 1);
    chk("t2_press_once", n_prs[0] - b_prs, 1);
    chk("t2_no_release", n_rel[0] - b_rel, 0);

    // Test 4: 2-tick release glitch while held.
    lvl_ok = 1'b1;
    key_raw = 1'b0;
    for (int t = 0; t < 20; t++) begin step(); lvl_ok &= lvl_a; end
    key_raw = 1'b1;
    for (int t = 0; t < 200; t++) begin step(); lvl_ok &= lvl_a; end
    chk("t4_level_stays", int'(lvl_ok), 1);
    chk("t4_no_release", n_rel[0] - b_rel, 0);

    // Test 5: reset in the middle of release debouncing.
    run(25, 1'b0);
    chk("t5_level_before_rst", int'(lvl_a), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_outs_a_zero", int'({lvl_a, prs_a, rel_a, rpt_a}), 0);
    chk("t5_outs_b_zero", int'({lvl_b, prs_b, rel_b, rpt_b}), 0);
    run(30, 1'b0);
    chk("t5_no_release", n_rel[0] - b_rel, 0);

    // Test 6b: tick_in high across reset release.
    div_en = 1'b0; tick_in = 1'b1; rst = 1'b1;
    run(3, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_first_tick", int'(dut_a.w_tick), 1);
    step();
    chk("t6_tick_one_cycle", int'(dut_a.w_tick), 0);
    div_en = 1'b1; div_cnt = 0;

    // Randomised segments checked cycle by cycle against the model.
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 24) == 0) begin rst = 1'b1; step(); rst = 1'b0; end
      run(($urandom_range(0, 9) == 0) ? 700 : int'($urandom_range(1, 70)),
          1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
